uart_rx_byte: RTL and testbench

Serial UART receiver for the inter-board tank-position link. It turns the asynchronous `rx` line into byte strobes (`rx_done` + `current_rx`) for the downstream frame register. That register strips the 4×0xFF preamble and assembles X/Y positions. The receiver uses 16× oversampling, mid-bit sampling and a 2-flop input synchronizer. Default format is 8N1; even parity can be compiled in.

---
 rtl/uart_rx_byte_if.sv | 22 ++
 rtl/uart_rx_byte.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_byte_if.sv
// Serial line plus byte-strobe bundle between the UART receiver (slave)
// and the side that drives the line and consumes the received bytes (master).
interface uart_rx_byte_if;
  logic       rx;
  logic       rx_done;
  logic [7:0] current_rx;
  logic       rx_err;

  modport master (
    output rx,
    input  rx_done,
    input  current_rx,
    input  rx_err
  );

  modport slave (
    input  rx,
    output rx_done,
    output current_rx,
    output rx_err
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 16x-oversampled UART byte receiver with mid-bit sampling, 8N1 by default.
// Define UART_RX_PARITY_EN to build an 8E1 receiver with even-parity checking.
module uart_rx_byte #(
  parameter int TICK_DIV = 54
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_byte_if.slave bus
);

  localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           r_state;
  state_t           w_next;

  logic             r_sync1;
  logic             r_rxs;
  logic             r_rxs_prev;

  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_os;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;

  logic             r_done;
  logic             r_err;
  logic [7:0]       r_cur;

  logic             w_tick;
  logic             w_mid;
  logic             w_end;
  logic             w_cnt_clr;
  logic             w_shift_en;
  logic             w_done_set;
  logic             w_err_set;
  logic             w_par_bad;

  // Input synchronizer; idles high so reset never looks like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync1    <= bus.rx;
      r_rxs      <= r_sync1;
      r_rxs_prev <= r_rxs;
    end
  end

  assign w_tick = (r_div == DIV_LAST);
  assign w_mid  = w_tick && (r_os == 4'd7);
  assign w_end  = w_tick && (r_os == 4'd15);

  // Tick divider and oversample counter, held at zero while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_os  <= 4'd0;
    end else if (w_cnt_clr || (r_state == S_IDLE)) begin
      r_div <= '0;
      r_os  <= 4'd0;
    end else if (w_tick) begin
      r_div <= '0;
      r_os  <= r_os + 4'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit <= 3'd0;
    end else if (w_cnt_clr) begin
      r_bit <= 3'd0;
    end else if (w_shift_en) begin
      r_bit <= r_bit + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_shift_en) begin
      r_shift <= {r_rxs, r_shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic w_par_en;
  logic r_par_err;

  // Even parity: data bits plus parity bit must XOR to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (w_cnt_clr) begin
      r_par_err <= 1'b0;
    end else if (w_par_en) begin
      r_par_err <= ^{r_shift, r_rxs};
    end
  end

  assign w_par_bad = r_par_err;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_done_set = 1'b0;
    w_err_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_en   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // Edge-triggered so a held-low break line cannot retrigger
        if (r_rxs_prev && !r_rxs) begin
          w_next    = S_START;
          w_cnt_clr = 1'b1;
        end
      end
      S_START: begin
        if (w_mid) begin
          w_cnt_clr = 1'b1;
          w_next    = r_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_end) begin
          w_shift_en = 1'b1;
          if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_next = S_PARITY;
`else
            w_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_end) begin
          w_par_en = 1'b1;
          w_next   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leaving at mid-stop lets the next start edge land on full line rate
        if (w_end) begin
          w_next = S_IDLE;
          if (r_rxs && !w_par_bad) begin
            w_done_set = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_cur  <= 8'h00;
    end else begin
      r_done <= w_done_set;
      r_err  <= w_err_set;
      if (w_done_set) begin
        r_cur <= r_shift;
      end
    end
  end

  assign bus.rx_done    = r_done;
  assign bus.rx_err     = r_err;
  assign bus.current_rx = r_cur;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed and randomized frames on the serial line, checked against a
// frame-level model of expected strobes, bytes and strobe timing.
module tb_uart_rx_byte;

  localparam int TD  = 4;
  localparam int BIT = 16 * TD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // start edge -> 2 sync flops + edge compare, then frame length to mid-stop
  localparam int LAT = 3 + (PAR ? 168 : 152) * TD;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   both_hi = 0;
  int   cur_glitch = 0;
  logic [7:0] cur_prev = 8'h00;
  logic [7:0] model_cur;
  ev_t  got_q[$];
  ev_t  exp_q[$];

  uart_rx_byte_if bus();

  uart_rx_byte #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst) begin
      if (bus.rx_done || bus.rx_err) begin
        e.err  = bus.rx_err;
        e.data = bus.current_rx;
        e.cyc  = cyc;
        got_q.push_back(e);
        if (bus.rx_done && bus.rx_err) both_hi++;
      end
      if (bus.current_rx !== cur_prev && !bus.rx_done) cur_glitch++;
    end
    cur_prev = bus.current_rx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, input bit stop);
    ev_t e;
    bit  good;
    good = stop && !(PAR && ((^d) ^ p));
    if (good) model_cur = d;
    e.err  = !good;
    e.data = model_cur;
    e.cyc  = cyc + LAT;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR) drive_bit(p);
    drive_bit(stop);
    bus.rx = 1'b1;
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_kind"}, 32'(got_q[i].err), 32'(exp_q[i].err));
      chk({tag, "_byte"}, 32'(got_q[i].data), 32'(exp_q[i].data));
      chk({tag, "_time"}, 32'(got_q[i].cyc), 32'(exp_q[i].cyc));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] burst [8];
    logic [7:0] d;
    logic [7:0] part;
    bit         p;
    bit         stop;
    int         gap;

    burst = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h34, 8'h12, 8'h78, 8'h56};
    bus.rx    = 1'b1;
    rst       = 1'b1;
    model_cur = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_done", 32'(bus.rx_done), 32'd0);
    chk("rst_err",  32'(bus.rx_err),  32'd0);
    chk("rst_cur",  32'(bus.current_rx), 32'h00);
    rst = 1'b0;

    idle(1000);
    chk("idle_done", 32'(bus.rx_done), 32'd0);
    chk("idle_err",  32'(bus.rx_err),  32'd0);
    chk("idle_cur",  32'(bus.current_rx), 32'h00);
    check_events("idle");

    send_frame(8'hA5, ^8'hA5, 1'b1);
    idle(2 * BIT);
    check_events("a5");
    chk("a5_hold", 32'(bus.current_rx), 32'hA5);

    for (int i = 0; i < 8; i++) send_frame(burst[i], ^burst[i], 1'b1);
    idle(2 * BIT);
    check_events("burst");

    send_frame(8'h3C, ^8'h3C, 1'b0);
    idle(2 * BIT);
    send_frame(8'h3C, ^8'h3C, 1'b1);
    idle(2 * BIT);
    check_events("badstop");

    bus.rx = 1'b0;
    repeat (2 * TD) @(posedge clk);
    #1;
    idle(2 * BIT);
    check_events("glitch");
    send_frame(8'h81, ^8'h81, 1'b1);
    idle(2 * BIT);
    check_events("after_glitch");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * BIT);
    send_frame(8'h07, 1'b0, 1'b1);
    idle(2 * BIT);
    check_events("parity");
    chk("parity_hold", 32'(bus.current_rx), 32'h07);
`endif

    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom_range(0, 255));
      p    = (^d) ^ ($urandom_range(0, 4) == 0);
      stop = ($urandom_range(0, 6) != 0);
      send_frame(d, p, stop);
      gap = stop ? $urandom_range(0, BIT) : $urandom_range(16, BIT);
      if (gap > 0) idle(gap);
    end
    idle(2 * BIT);
    check_events("random");

    part = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(part[i]);
    bus.rx = part[3];
    repeat (BIT / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_done", 32'(bus.rx_done), 32'd0);
    chk("midrst_err",  32'(bus.rx_err),  32'd0);
    chk("midrst_cur",  32'(bus.current_rx), 32'h00);
    repeat (3) @(posedge clk);
    #1;
    bus.rx    = 1'b1;
    rst       = 1'b0;
    model_cur = 8'h00;
    idle(1000);
    check_events("midrst");
    chk("midrst_idle_cur", 32'(bus.current_rx), 32'h00);
    send_frame(8'hC3, ^8'hC3, 1'b1);
    idle(2 * BIT);
    check_events("after_rst");

    chk("strobe_overlap", 32'(both_hi), 32'd0);
    chk("cur_unstrobed_change", 32'(cur_glitch), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
